// File: rtl/btle_scan_pkg.sv
// Shared types and constants for the BLE advertising scan scheduler.
// State encoding, advertising-channel defaults and channel index helpers.
package btle_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TUNE,
        LISTEN,
        RECEIVE,
        REPORT
    } scan_state_e;

    localparam logic [31:0] ADV_ACCESS_ADDRESS = 32'h8E89BED6;
    localparam logic [23:0] ADV_CRC_INIT       = 24'h555555;

    localparam logic [5:0] ADV_CH37 = 6'd37;
    localparam logic [5:0] ADV_CH38 = 6'd38;
    localparam logic [5:0] ADV_CH39 = 6'd39;

    // Index 0/1/2 maps onto advertising channel 37/38/39.
    function automatic logic [5:0] adv_idx_to_chan(input logic [1:0] idx);
        return ADV_CH37 + {4'd0, idx};
    endfunction

endpackage

// File: rtl/btle_adv_channel_sel.sv
// Combinational lookup of the next enabled advertising channel (ascending,
// 39 wraps to 37) and of the lowest enabled channel. An empty mask means all three.
module btle_adv_channel_sel
    import btle_scan_pkg::*;
#(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6
) (
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cur_chan_i,
    input  logic [2:0]                          mask_i,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] next_chan_o,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] first_chan_o
);

    localparam int CW = CHANNEL_NUMBER_BIT_WIDTH;

    logic [2:0] eff_mask;
    logic [1:0] cur_idx;
    logic [1:0] next_idx;
    logic [1:0] first_idx;

    // The last candidate is always enabled when the earlier two are not,
    // because the effective mask is never empty.
    function automatic logic [1:0] pick(input logic [2:0] m, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
        if (m[a]) return a;
        if (m[b]) return b;
        return c;
    endfunction

    always_comb begin
        eff_mask = (mask_i == 3'b000) ? 3'b111 : mask_i;

        if (cur_chan_i == CW'(ADV_CH38)) begin
            cur_idx = 2'd1;
        end else if (cur_chan_i == CW'(ADV_CH39)) begin
            cur_idx = 2'd2;
        end else begin
            cur_idx = 2'd0;
        end

        case (cur_idx)
            2'd0:    next_idx = pick(eff_mask, 2'd1, 2'd2, 2'd0);
            2'd1:    next_idx = pick(eff_mask, 2'd2, 2'd0, 2'd1);
            default: next_idx = pick(eff_mask, 2'd0, 2'd1, 2'd2);
        endcase

        first_idx = pick(eff_mask, 2'd0, 2'd1, 2'd2);
    end

    assign next_chan_o  = CW'(adv_idx_to_chan(next_idx));
    assign first_chan_o = CW'(adv_idx_to_chan(first_idx));

endmodule

// File: rtl/btle_adv_scan_ctrl.sv
// Scan scheduler driving btle_rx_core across advertising channels 37/38/39.
// Optional macro BTLE_SCAN_STATS_EN adds saturating packet / error counters.
module btle_adv_scan_ctrl
    import btle_scan_pkg::*;
#(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int LEN_UNIQUE_BIT_SEQUENCE  = 32,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int WINDOW_BIT_WIDTH         = 20,
    parameter int SETTLE_CYCLES            = 16,
    parameter int PKT_TIMEOUT_CYCLES       = 40000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                scan_en,
    input  logic [2:0]                          channel_mask,
    input  logic [WINDOW_BIT_WIDTH-1:0]         window_cycles,
    input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  access_address,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_init,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    output logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]  unique_bit_sequence,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    output logic                                core_rst,
    output logic                                rx_iq_en,
    input  logic                                hit_flag,
    input  logic [6:0]                          payload_length,
    input  logic                                payload_length_valid,
    input  logic                                decode_end,
    input  logic                                crc_ok,
    output logic                                pkt_valid,
    output logic [5:0]                          pkt_channel,
    output logic [6:0]                          pkt_length,
    output logic                                pkt_crc_ok,
    output logic                                pkt_timeout,
    output logic                                busy,
    output logic [15:0]                         pkt_count,
    output logic [15:0]                         crc_err_count
);

    localparam int CW = CHANNEL_NUMBER_BIT_WIDTH;
    localparam int WW = WINDOW_BIT_WIDTH;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(PKT_TIMEOUT_CYCLES + 1);

    scan_state_e state_q, state_d;
    logic [CW-1:0]                      chan_q, chan_d;
    logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] aa_q, aa_d;
    logic [CRC_STATE_BIT_WIDTH-1:0]     crc_q, crc_d;
    logic [WW-1:0]                      win_q, win_d;
    logic [SW-1:0]                      settle_q, settle_d;
    logic [TW-1:0]                      to_cnt_q, to_cnt_d;
    logic [6:0]                         len_q, len_d;
    logic [5:0]                         rpt_chan_q, rpt_chan_d;
    logic [6:0]                         rpt_len_q, rpt_len_d;
    logic                               rpt_crc_q, rpt_crc_d;
    logic                               rpt_to_q, rpt_to_d;

    logic          enter_tune;
    logic          tune_first;
    logic [CW-1:0] next_chan;
    logic [CW-1:0] first_chan;
    logic [WW-1:0] win_load;
    logic [6:0]    len_now;

    btle_adv_channel_sel #(
        .CHANNEL_NUMBER_BIT_WIDTH(CW)
    ) u_chan_sel (
        .cur_chan_i  (chan_q),
        .mask_i      (channel_mask),
        .next_chan_o (next_chan),
        .first_chan_o(first_chan)
    );

    assign win_load = (window_cycles == '0) ? WW'(1) : window_cycles;
    assign len_now  = payload_length_valid ? payload_length : len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            chan_q     <= CW'(ADV_CH37);
            aa_q       <= LEN_UNIQUE_BIT_SEQUENCE'(ADV_ACCESS_ADDRESS);
            crc_q      <= CRC_STATE_BIT_WIDTH'(ADV_CRC_INIT);
            win_q      <= '0;
            settle_q   <= '0;
            to_cnt_q   <= '0;
            len_q      <= '0;
            rpt_chan_q <= '0;
            rpt_len_q  <= '0;
            rpt_crc_q  <= 1'b0;
            rpt_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            aa_q       <= aa_d;
            crc_q      <= crc_d;
            win_q      <= win_d;
            settle_q   <= settle_d;
            to_cnt_q   <= to_cnt_d;
            len_q      <= len_d;
            rpt_chan_q <= rpt_chan_d;
            rpt_len_q  <= rpt_len_d;
            rpt_crc_q  <= rpt_crc_d;
            rpt_to_q   <= rpt_to_d;
        end
    end

    // The listen cycle in which hit_flag arrives still consumes window;
    // the counter then stays frozen through RECEIVE and REPORT.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        aa_d       = aa_q;
        crc_d      = crc_q;
        win_d      = win_q;
        settle_d   = settle_q;
        to_cnt_d   = to_cnt_q;
        len_d      = len_q;
        rpt_chan_d = rpt_chan_q;
        rpt_len_d  = rpt_len_q;
        rpt_crc_d  = rpt_crc_q;
        rpt_to_d   = rpt_to_q;
        enter_tune = 1'b0;
        tune_first = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_en) begin
                    aa_d       = access_address;
                    crc_d      = crc_init;
                    state_d    = TUNE;
                    enter_tune = 1'b1;
                    tune_first = 1'b1;
                end
            end
            TUNE: begin
                if (!scan_en) begin
                    state_d = IDLE;
                end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = LISTEN;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            LISTEN: begin
                if (!scan_en) begin
                    state_d = IDLE;
                end else begin
                    win_d = win_q - WW'(1);
                    if (hit_flag) begin
                        state_d  = RECEIVE;
                        to_cnt_d = '0;
                        len_d    = '0;
                    end else if (win_q <= WW'(1)) begin
                        state_d    = TUNE;
                        enter_tune = 1'b1;
                    end
                end
            end
            RECEIVE: begin
                len_d    = len_now;
                to_cnt_d = to_cnt_q + TW'(1);
                if (decode_end) begin
                    state_d    = REPORT;
                    rpt_chan_d = 6'(chan_q);
                    rpt_len_d  = len_now;
                    rpt_crc_d  = crc_ok;
                    rpt_to_d   = 1'b0;
                end else if (to_cnt_q == TW'(PKT_TIMEOUT_CYCLES - 1)) begin
                    state_d    = REPORT;
                    rpt_chan_d = 6'(chan_q);
                    rpt_len_d  = len_now;
                    rpt_crc_d  = 1'b0;
                    rpt_to_d   = 1'b1;
                end
            end
            REPORT: begin
                if (!scan_en) begin
                    state_d = IDLE;
                end else if (rpt_to_q || (win_q == '0)) begin
                    state_d    = TUNE;
                    enter_tune = 1'b1;
                end else begin
                    state_d = LISTEN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_tune) begin
            chan_d   = tune_first ? first_chan : next_chan;
            win_d    = win_load;
            settle_d = '0;
        end
    end

    assign channel_number      = chan_q;
    assign unique_bit_sequence = aa_q;
    assign crc_state_init_bit  = crc_q;
    assign core_rst            = (state_q == IDLE) || (state_q == TUNE);
    assign rx_iq_en            = (state_q == LISTEN);
    assign busy                = (state_q != IDLE);
    assign pkt_valid           = (state_q == REPORT);
    assign pkt_channel         = rpt_chan_q;
    assign pkt_length          = rpt_len_q;
    assign pkt_crc_ok          = rpt_crc_q;
    assign pkt_timeout         = rpt_to_q;

`ifdef BTLE_SCAN_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (pkt_valid) begin
            if (pkt_cnt_q != 16'hFFFF) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if ((!rpt_crc_q || rpt_to_q) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_count     = pkt_cnt_q;
    assign crc_err_count = err_cnt_q;
`else
    assign pkt_count     = 16'd0;
    assign crc_err_count = 16'd0;
`endif

endmodule

// File: doc/btle_adv_scan_ctrl.md
Name: btle_adv_scan_ctrl

Overview:
Scan scheduler that sequences btle_rx_core across the BLE advertising channels 37/38/39. Per channel it configures channel_number, access address and CRC init, and resets the core on every retune. It runs a listen window per channel, guards active packets with a timeout, and reports one result record per packet. It sits between the register/config layer and btle_rx_core.

Parameters:
CHANNEL_NUMBER_BIT_WIDTH, 6, channel index width
LEN_UNIQUE_BIT_SEQUENCE, 32, access address width
CRC_STATE_BIT_WIDTH, 24, CRC init width
WINDOW_BIT_WIDTH, 20, listen window counter width
SETTLE_CYCLES, 16, core_rst hold cycles on retune (>=2)
PKT_TIMEOUT_CYCLES, 40000, max cycles from hit_flag to decode_end

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
scan_en  in  1  level; high = scanning
channel_mask  in  3  bit0=37, bit1=38, bit2=39; sampled on every TUNE entry
window_cycles  in  WINDOW_BIT_WIDTH  listen cycles per channel; sampled on TUNE entry
access_address  in  32  sampled on IDLE exit
crc_init  in  24  sampled on IDLE exit
channel_number  out  CHANNEL_NUMBER_BIT_WIDTH  to core
unique_bit_sequence  out  32  to core
crc_state_init_bit  out  24  to core
core_rst  out  1  synchronous reset to core
rx_iq_en  out  1  gates iq_valid into core
hit_flag  in  1  from core
payload_length  in  7  from core
payload_length_valid  in  1  from core
decode_end  in  1  from core
crc_ok  in  1  from core
pkt_valid  out  1  one-cycle result strobe
pkt_channel  out  6  channel of result
pkt_length  out  7  captured payload_length
pkt_crc_ok  out  1  result CRC status
pkt_timeout  out  1  result ended by timeout
busy  out  1  state != IDLE
pkt_count  out  16  saturating packet counter (optional)
crc_err_count  out  16  saturating CRC/timeout error counter (optional)

Behaviour:
- Reset values: channel_number=37, unique_bit_sequence=32'h8E89BED6, crc_state_init_bit=24'h555555, core_rst=1, rx_iq_en=0, all pkt_* =0, busy=0, counters=0, state IDLE.
- IDLE:
  - core_rst=1, rx_iq_en=0.
  - scan_en=1 -> latch access_address/crc_init, select lowest enabled channel, go to TUNE next cycle.
- TUNE:
  - On entry, register channel_number, sample mask and window.
  - core_rst=1 for exactly SETTLE_CYCLES cycles, then LISTEN.
  - hit_flag ignored.
- LISTEN:
  - rx_iq_en=1, core_rst=0; window counter decrements each cycle.
  - hit_flag -> RECEIVE; window counter frozen; timeout counter cleared.
  - Counter reaching 0 -> TUNE on next enabled channel, ascending and cyclic (39 wraps to 37).
  - A single enabled channel retunes the same channel.
  - hit_flag and expiry in the same cycle -> RECEIVE wins.
- RECEIVE:
  - Capture pkt_length on payload_length_valid.
  - decode_end -> REPORT with crc_ok.
  - Timeout after PKT_TIMEOUT_CYCLES -> REPORT with timeout=1, crc_ok=0.
  - decode_end and timeout in the same cycle -> decode_end wins.
- REPORT (1 cycle):
  - pkt_valid=1; pkt_* held stable until the next report.
  - If timeout, or scan_en=0, or window=0 -> TUNE (next channel), or IDLE if scan_en=0.
  - Otherwise -> LISTEN with the remaining window.
- scan_en falling:
  - In TUNE/LISTEN -> IDLE next cycle.
  - In RECEIVE -> complete the packet, report, then IDLE.
- Degenerate config:
  - channel_mask=0 is treated as 3'b111.
  - window_cycles=0 is treated as 1.
- Latency: scan_en rise to first rx_iq_en = 1+SETTLE_CYCLES cycles. decode_end to pkt_valid = 1 cycle.

Optional Feature:
BTLE_SCAN_STATS_EN:
- Defined:
  - pkt_count increments on every pkt_valid.
  - crc_err_count increments when pkt_valid and (!pkt_crc_ok or pkt_timeout).
  - Both saturate at 16'hFFFF and clear only on rst.
- Undefined: both ports tied to 0 and no counter flops exist.

Decomposition:
- Shared package btle_scan_pkg: state encoding (IDLE, TUNE, LISTEN, RECEIVE, REPORT); constants ADV_ACCESS_ADDRESS=32'h8E89BED6, ADV_CRC_INIT=24'h555555, channel indices 37/38/39.
- One natural sub-module, btle_adv_channel_sel: combinational next-enabled-channel lookup from the current channel and mask.

Test Plan:
- scan_en=1, mask=3'b111, window=100, no hits -> channel sequence 37,38,39,37. Each dwell = SETTLE_CYCLES+100 cycles, core_rst high exactly 16 cycles per hop.
- In LISTEN on 38, pulse hit_flag; 20 cycles later decode_end=1, crc_ok=1, payload_length=12 -> pkt_valid 1 cycle later with channel=38, length=12, crc_ok=1, timeout=0. Returns to LISTEN with the remaining window.
- hit_flag with no decode_end -> pkt_timeout=1, crc_ok=0 after 40000 cycles. Retune via TUNE; crc_err_count=1 with BTLE_SCAN_STATS_EN.
- mask=3'b100 -> only channel 39, retuned every window. mask=0 behaves as 3'b111.
- scan_en dropped mid-RECEIVE -> packet still reported, then IDLE with core_rst=1, busy=0.
- rst asserted mid-LISTEN -> all outputs take reset values immediately, asynchronously.
